kbd_text_ctrl: RTL and testbench
================================

Name: kbd_text_ctrl

Overview:
- Sequencer between the PS/2 scancode receiver and the keyboard display path: the scancode→ASCII lookup table and the 4096-byte character buffer scanned by VGA as {h_count, v_count}.
- Consumes raw scancodes and filters break (F0) and extended (E0) sequences.
- Looks up ASCII through the table's 1-cycle read port, tracks a text cursor, and issues single-byte writes into the character buffer.
- After reset, clears the whole buffer before accepting keys.

Parameters:
- ROWS, 30, text rows in use (≤32); row index is buffer address bits [11:7].
- COLS, 70, text columns in use (≤128); column index is buffer address bits [6:0].

Ports:
- clk  input  1  system clock.
- clrn  input  1  synchronous active-low reset, sampled on posedge clk.
- sc_data  input  8  scancode byte from the PS/2 receiver.
- sc_valid  input  1  sc_data valid.
- sc_ready  output  1  controller accepts sc_data this cycle.
- lut_addr  output  8  scancode table read address (registered).
- lut_data  input  8  ASCII from the table, valid the cycle after lut_addr changes.
- buf_we  output  1  character buffer write strobe, one-cycle pulse.
- buf_addr  output  12  write address {row[4:0], col[6:0]}.
- buf_data  output  8  write data.
- cur_row  output  5  current cursor row.
- cur_col  output  7  current cursor column.

Behaviour:
- Reset (clrn=0 at posedge): state CLEAR, clear_cnt=0, cursor (0,0), prefix flags cleared; buf_we=0, buf_addr=0, buf_data=0, lut_addr=0, sc_ready=0. Reset mid-operation aborts any state, including an in-progress CLEAR, and restarts CLEAR from address 0.
- Handshake: a transfer occurs on a posedge with sc_valid&sc_ready. sc_ready=1 only in IDLE. sc_data is captured on the transfer.
- CLEAR: each cycle drives buf_we=1, buf_addr=clear_cnt, buf_data=0x00, then clear_cnt+1. All 4096 addresses are written (0x000..0xFFF). Transitions to IDLE after 0xFFF. buf_we drops the cycle IDLE is entered.
- IDLE: on transfer:
  - 0xE0: set ext flag, stay IDLE.
  - 0xF0: set brk flag, stay IDLE.
  - Other code with brk or ext set: clear both flags, stay IDLE. Break codes and extended keys produce no write.
  - Else: lut_addr<=code, go LOOKUP.
- LOOKUP (1 cycle): waits for table read latency, then goes WRITE.
- WRITE (1 cycle): decodes lut_data. Output registers load at the end of this cycle, and the state returns to IDLE.
  - 0x20..0x7E: buf_we=1, buf_addr={row,col}, buf_data=lut_data, then advance the cursor.
  - 0x0D (Enter): col=0, row advances; no write.
  - 0x08 (Backspace): if col>0, col-1; else if row>0, row-1 and col=COLS-1; else no movement and no write. When the cursor moved, write 0x00 at the new position.
  - Anything else, including 0x00: ignored.
- Cursor advance: col==COLS-1 → col=0 and row advances; else col+1. Row advance: row==ROWS-1 → row=0 (wrap, no scroll); else row+1.
- Latency: transfer at edge N → lut_addr valid N+1 → WRITE decode N+2 → buf_we high for exactly the cycle after edge N+3. sc_ready is high again from edge N+3, so a new key can be accepted every 3 cycles.
- Back-to-back: only one scancode is in flight; sc_ready=0 holds the producer.
- buf_we is never high for two consecutive cycles outside CLEAR.
- cur_row and cur_col reflect the registered cursor and update at the same edge as the write.

Decomposition:
- Shared package kbd_pkg holds:
  - constants SC_BREAK=8'hF0, SC_EXT=8'hE0, ASCII_CR=8'h0D, ASCII_BS=8'h08, ASCII_MIN=8'h20, ASCII_MAX=8'h7E, BUF_AW=12;
  - state enum {CLEAR, IDLE, LOOKUP, WRITE}.
- One sub-module is natural: text_cursor. It holds the row/col registers with inputs advance, newline, backspace. It outputs row, col and moved, and handles the COLS/ROWS wrap rules.
- The FSM, prefix flags and output registers stay in kbd_text_ctrl.

Test Plan:
- Reset release: clrn 0→1 → buf_we high exactly 4096 cycles with buf_addr 0x000..0xFFF and data 0x00; sc_ready rises the cycle after address 0xFFF.
- Key press: sc_data=0x1C, table returns 0x61 → lut_addr=0x1C at N+1; single buf_we with addr 0x000, data 0x61 after edge N+3; cur_col=1.
- Break and extended codes: send F0,1C → no write; then E0,75 and E0,F0,75 → no write. Flags are cleared afterwards: plain 0x1C still writes.
- Line wrap: 70 presses of 0x1C → last write addr 0x045 (col 69), cursor (1,0). Enter (0x5A→0x0D) at row 29 → cursor (0,0), no write.
- Backspace: at (1,0) send 0x66 (→0x08) → write 0x00 at addr 0x045, cursor (0,69). Backspace at (0,0) → no write, cursor unchanged.
- Reset mid-op: assert clrn low during LOOKUP and during CLEAR address 0x800 → next cycle buf_we=0; on release, CLEAR restarts at 0x000 and cursor is (0,0).

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared constants and state encoding for the keyboard text controller.
package kbd_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_MIN = 8'h20;
  localparam logic [7:0] ASCII_MAX = 8'h7E;

  localparam int ROW_W  = 5;
  localparam int COL_W  = 7;
  localparam int BUF_AW = 12;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    IDLE   = 2'd1,
    LOOKUP = 2'd2,
    WRITE  = 2'd3
  } state_e;

endpackage

// File: rtl/text_cursor.sv
// Text cursor with column/row wrap; exposes the next position so a write can
// target the post-move location in the same cycle the cursor moves.
module text_cursor
  import kbd_pkg::*;
#(
  parameter int ROWS = 30,
  parameter int COLS = 70
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             advance,
  input  logic             newline,
  input  logic             backspace,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row_nxt,
  output logic [COL_W-1:0] col_nxt,
  output logic             moved
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  logic [ROW_W-1:0] row_q, row_d, row_inc;
  logic [COL_W-1:0] col_q, col_d;

  // next cursor position from the one-hot-ish move strobes
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    row_inc = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
    if (advance) begin
      if (col_q == COL_LAST) begin
        col_d = 7'd0;
        row_d = row_inc;
      end else begin
        col_d = col_q + 7'd1;
      end
    end else if (newline) begin
      col_d = 7'd0;
      row_d = row_inc;
    end else if (backspace) begin
      if (col_q != 7'd0) begin
        col_d = col_q - 7'd1;
      end else if (row_q != 5'd0) begin
        row_d = row_q - 5'd1;
        col_d = COL_LAST;
      end else begin
        col_d = col_q;
      end
    end else begin
      row_d = row_q;
    end
  end

  // cursor registers
  always_ff @(posedge clk) begin
    if (!clrn) begin
      row_q <= 5'd0;
      col_q <= 7'd0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row     = row_q;
  assign col     = col_q;
  assign row_nxt = row_d;
  assign col_nxt = col_d;
  assign moved   = (row_d != row_q) || (col_d != col_q);

endmodule

// File: rtl/kbd_text_ctrl.sv
// Scancode-to-character-buffer sequencer: clears the buffer after reset, then
// filters break/extended prefixes, looks up ASCII and writes at the cursor.
module kbd_text_ctrl
  import kbd_pkg::*;
#(
  parameter int ROWS = 30,
  parameter int COLS = 70
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [7:0]        sc_data,
  input  logic              sc_valid,
  output logic              sc_ready,
  output logic [7:0]        lut_addr,
  input  logic [7:0]        lut_data,
  output logic              buf_we,
  output logic [BUF_AW-1:0] buf_addr,
  output logic [7:0]        buf_data,
  output logic [ROW_W-1:0]  cur_row,
  output logic [COL_W-1:0]  cur_col
);

  state_e            state_q, state_d;
  logic [BUF_AW:0]   clear_cnt_q, clear_cnt_d;
  logic              ext_q, ext_d, brk_q, brk_d;
  logic [7:0]        lut_addr_q, lut_addr_d;
  logic              buf_we_q, buf_we_d;
  logic [BUF_AW-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]        buf_data_q, buf_data_d;
  logic              sc_ready_q, sc_ready_d;
  logic              cur_adv_s, cur_nl_s, cur_bs_s, cur_moved_s;
  logic [ROW_W-1:0]  row_nxt_s;
  logic [COL_W-1:0]  col_nxt_s;

  text_cursor #(.ROWS(ROWS), .COLS(COLS)) u_cursor (
    .clk      (clk),
    .clrn     (clrn),
    .advance  (cur_adv_s),
    .newline  (cur_nl_s),
    .backspace(cur_bs_s),
    .row      (cur_row),
    .col      (cur_col),
    .row_nxt  (row_nxt_s),
    .col_nxt  (col_nxt_s),
    .moved    (cur_moved_s)
  );

  // sequencer next-state and output-register inputs
  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    lut_addr_d  = lut_addr_q;
    buf_we_d    = 1'b0;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    cur_adv_s   = 1'b0;
    cur_nl_s    = 1'b0;
    cur_bs_s    = 1'b0;
    case (state_q)
      CLEAR: begin
        // top counter bit marks that address 0xFFF has already been issued
        if (clear_cnt_q[BUF_AW]) begin
          state_d = IDLE;
        end else begin
          buf_we_d    = 1'b1;
          buf_addr_d  = clear_cnt_q[BUF_AW-1:0];
          buf_data_d  = 8'h00;
          clear_cnt_d = clear_cnt_q + 13'd1;
        end
      end
      IDLE: begin
        if (sc_valid && sc_ready_q) begin
          if (sc_data == SC_EXT) begin
            ext_d = 1'b1;
          end else if (sc_data == SC_BREAK) begin
            brk_d = 1'b1;
          end else if (ext_q || brk_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else begin
            lut_addr_d = sc_data;
            state_d    = LOOKUP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        state_d = WRITE;
      end
      WRITE: begin
        state_d = IDLE;
        if ((lut_data >= ASCII_MIN) && (lut_data <= ASCII_MAX)) begin
          buf_we_d   = 1'b1;
          buf_addr_d = {cur_row, cur_col};
          buf_data_d = lut_data;
          cur_adv_s  = 1'b1;
        end else if (lut_data == ASCII_CR) begin
          cur_nl_s = 1'b1;
        end else if (lut_data == ASCII_BS) begin
          cur_bs_s   = 1'b1;
          buf_we_d   = cur_moved_s;
          buf_addr_d = {row_nxt_s, col_nxt_s};
          buf_data_d = 8'h00;
        end else begin
          buf_we_d = 1'b0;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
    sc_ready_d = (state_d == IDLE);
  end

  // state, prefix flags and registered outputs
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q     <= CLEAR;
      clear_cnt_q <= 13'd0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      lut_addr_q  <= 8'h00;
      buf_we_q    <= 1'b0;
      buf_addr_q  <= 12'h000;
      buf_data_q  <= 8'h00;
      sc_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      lut_addr_q  <= lut_addr_d;
      buf_we_q    <= buf_we_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      sc_ready_q  <= sc_ready_d;
    end
  end

  assign sc_ready = sc_ready_q;
  assign lut_addr = lut_addr_q;
  assign buf_we   = buf_we_q;
  assign buf_addr = buf_addr_q;
  assign buf_data = buf_data_q;

endmodule

// File: tb/tb_kbd_text_ctrl.sv
// Randomized bench for kbd_text_ctrl against a linear-position text model.
module tb_kbd_text_ctrl;

  localparam int ROWS = 30;
  localparam int COLS = 70;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        sc_valid = 1'b0;
  logic [7:0]  sc_data = 8'h00;
  logic [7:0]  lut_data = 8'h00;
  logic        sc_ready, buf_we;
  logic [7:0]  lut_addr, buf_data;
  logic [11:0] buf_addr;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] lut_mem [256];
  int m_row, m_col;
  bit m_ext, m_brk;

  kbd_text_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .clrn(clrn), .sc_data(sc_data), .sc_valid(sc_valid),
    .sc_ready(sc_ready), .lut_addr(lut_addr), .lut_data(lut_data),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
    .cur_row(cur_row), .cur_col(cur_col)
  );

  always #5 clk = ~clk;

  // scancode table with one-cycle read latency
  always @(posedge clk) lut_data <= lut_mem[lut_addr];

  task automatic model_reset();
    m_row = 0; m_col = 0; m_ext = 0; m_brk = 0;
  endtask

  // Reference: cursor as linear position p = row*COLS + col.
  task automatic model_key(input logic [7:0] code, output int ew,
                           output logic [11:0] ea, output logic [7:0] ed);
    int p;
    logic [7:0] a;
    ew = 0; ea = 12'h000; ed = 8'h00;
    if (code == 8'hE0) m_ext = 1;
    else if (code == 8'hF0) m_brk = 1;
    else if (m_ext || m_brk) begin
      m_ext = 0; m_brk = 0;
    end else begin
      a = lut_mem[code];
      p = m_row * COLS + m_col;
      if (a >= 8'h20 && a <= 8'h7E) begin
        ew = 1; ea = 12'(m_row * 128 + m_col); ed = a;
        p = (p + 1) % (ROWS * COLS);
        m_row = p / COLS; m_col = p % COLS;
      end else if (a == 8'h0D) begin
        m_row = (m_row + 1) % ROWS; m_col = 0;
      end else if (a == 8'h08 && p > 0) begin
        p = p - 1;
        m_row = p / COLS; m_col = p % COLS;
        ew = 1; ea = 12'(m_row * 128 + m_col); ed = 8'h00;
      end
    end
  endtask

  task automatic wait_clear_done();
    int t = 0;
    @(negedge clk);
    while (!sc_ready && t < 6000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (sc_ready !== 1'b1) begin
      n_err++;
      $display("FAIL clear_timeout sc_ready=%b required 1", sc_ready);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); clrn = 1'b0;
    @(negedge clk); clrn = 1'b1;
    model_reset();
    wait_clear_done();
  endtask

  // Presents one scancode and observes the four following cycles.
  task automatic send_key(input logic [7:0] code, output int nw, output int wi,
                          output logic [11:0] wa, output logic [7:0] wd,
                          output logic [7:0] la, output bit tmo);
    int t = 0;
    nw = 0; wi = -1; wa = 12'h000; wd = 8'h00; la = 8'h00; tmo = 0;
    while (!sc_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!sc_ready) begin
      tmo = 1;
      return;
    end
    sc_data = code; sc_valid = 1'b1;
    @(posedge clk); #1; sc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) la = lut_addr;
      if (buf_we === 1'b1) begin
        nw++; wi = i; wa = buf_addr; wd = buf_data;
      end
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    int first = -1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({buf_we, sc_ready, buf_addr, buf_data, lut_addr, cur_row, cur_col} !== 42'd0) begin
      n_err++;
      $display("FAIL reset_state we=%b rdy=%b addr=%h data=%h lut=%h cur=(%0d,%0d) required all 0",
               buf_we, sc_ready, buf_addr, buf_data, lut_addr, cur_row, cur_col);
    end
    clrn = 1'b1;
    model_reset();
    for (int k = 0; k < 4096; k++) begin
      @(negedge clk);
      if (!(buf_we === 1'b1 && buf_addr === 12'(k) && buf_data === 8'h00 && sc_ready === 1'b0)) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL clear_seq bad_cycles=%0d first_bad=%0d, required 0 bad cycles", bad, first);
    end
    @(negedge clk);
    n_cmp++;
    if (buf_we !== 1'b0 || sc_ready !== 1'b1) begin
      n_err++;
      $display("FAIL clear_end we=%b rdy=%b required we=0 rdy=1", buf_we, sc_ready);
    end
  endtask

  task automatic test_key_press();
    int nw, wi, ew; logic [11:0] wa, ea; logic [7:0] wd, ed, la; bit tmo;
    model_key(8'h1C, ew, ea, ed);
    send_key(8'h1C, nw, wi, wa, wd, la, tmo);
    n_cmp++;
    if (tmo || la !== 8'h1C) begin
      n_err++; $display("FAIL key_lut_addr got=%h required 1c", la);
    end
    n_cmp++;
    if (nw !== 1 || wi !== 2 || wa !== 12'h000 || wd !== 8'h61) begin
      n_err++;
      $display("FAIL key_write nw=%0d cyc=%0d addr=%h data=%h required 1/2/000/61", nw, wi, wa, wd);
    end
    n_cmp++;
    if (cur_row !== 5'd0 || cur_col !== 7'd1) begin
      n_err++; $display("FAIL key_cursor got=(%0d,%0d) required (0,1)", cur_row, cur_col);
    end
  endtask

  task automatic test_prefix();
    logic [7:0] seq [8] = '{8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h1C};
    int nw, wi, ew; logic [11:0] wa, ea; logic [7:0] wd, ed, la; bit tmo;
    for (int i = 0; i < 8; i++) begin
      model_key(seq[i], ew, ea, ed);
      send_key(seq[i], nw, wi, wa, wd, la, tmo);
      n_cmp++;
      if (tmo || nw !== ew || (ew == 1 && (wi !== 2 || wa !== ea || wd !== ed)) ||
          cur_row !== 5'(m_row) || cur_col !== 7'(m_col)) begin
        n_err++;
        $display("FAIL prefix[%0d] code=%h nw=%0d addr=%h data=%h cur=(%0d,%0d) required nw=%0d addr=%h data=%h cur=(%0d,%0d)",
                 i, seq[i], nw, wa, wd, cur_row, cur_col, ew, ea, ed, m_row, m_col);
      end
    end
  endtask

  task automatic test_line_wrap();
    int nw, wi, ew; logic [11:0] wa, ea, last; logic [7:0] wd, ed, la; bit tmo;
    do_reset();
    last = 12'hFFF;
    for (int i = 0; i < 70; i++) begin
      model_key(8'h1C, ew, ea, ed);
      send_key(8'h1C, nw, wi, wa, wd, la, tmo);
      if (nw == 1) last = wa;
      n_cmp++;
      if (tmo || nw !== ew || wa !== ea || wd !== ed || wi !== 2 ||
          cur_row !== 5'(m_row) || cur_col !== 7'(m_col)) begin
        n_err++;
        $display("FAIL wrap[%0d] nw=%0d addr=%h data=%h cur=(%0d,%0d) required addr=%h data=%h cur=(%0d,%0d)",
                 i, nw, wa, wd, cur_row, cur_col, ea, ed, m_row, m_col);
      end
    end
    n_cmp++;
    if (last !== 12'h045 || cur_row !== 5'd1 || cur_col !== 7'd0) begin
      n_err++;
      $display("FAIL wrap_end last=%h cur=(%0d,%0d) required 045 (1,0)", last, cur_row, cur_col);
    end
  endtask

  task automatic test_backspace();
    int nw, wi, ew; logic [11:0] wa, ea; logic [7:0] wd, ed, la; bit tmo;
    model_key(8'h66, ew, ea, ed);
    send_key(8'h66, nw, wi, wa, wd, la, tmo);
    n_cmp++;
    if (tmo || nw !== 1 || wi !== 2 || wa !== 12'h045 || wd !== 8'h00 ||
        cur_row !== 5'd0 || cur_col !== 7'd69) begin
      n_err++;
      $display("FAIL bs_row_wrap nw=%0d addr=%h data=%h cur=(%0d,%0d) required 1 045 00 (0,69)",
               nw, wa, wd, cur_row, cur_col);
    end
    for (int i = 0; i < 30; i++) begin
      model_key(8'h5A, ew, ea, ed);
      send_key(8'h5A, nw, wi, wa, wd, la, tmo);
      n_cmp++;
      if (tmo || nw !== 0 || cur_row !== 5'(m_row) || cur_col !== 7'(m_col)) begin
        n_err++;
        $display("FAIL enter[%0d] nw=%0d cur=(%0d,%0d) required nw=0 cur=(%0d,%0d)",
                 i, nw, cur_row, cur_col, m_row, m_col);
      end
    end
    n_cmp++;
    if (cur_row !== 5'd0 || cur_col !== 7'd0) begin
      n_err++; $display("FAIL enter_row_wrap cur=(%0d,%0d) required (0,0)", cur_row, cur_col);
    end
    model_key(8'h66, ew, ea, ed);
    send_key(8'h66, nw, wi, wa, wd, la, tmo);
    n_cmp++;
    if (tmo || nw !== 0 || cur_row !== 5'd0 || cur_col !== 7'd0) begin
      n_err++;
      $display("FAIL bs_origin nw=%0d cur=(%0d,%0d) required nw=0 (0,0)", nw, cur_row, cur_col);
    end
  endtask

  task automatic test_back_to_back();
    int xfers = 0, writes = 0, consec = 0, ew;
    logic prev_we = 1'b0;
    logic [11:0] ea; logic [7:0] ed;
    sc_data = 8'h1C;
    for (int c = 0; c < 36; c++) begin
      sc_valid = (c < 30);
      if (sc_valid && sc_ready) xfers++;
      @(negedge clk);
      if (buf_we === 1'b1) begin
        writes++;
        if (prev_we) consec++;
      end
      prev_we = buf_we;
    end
    sc_valid = 1'b0;
    for (int i = 0; i < 10; i++) model_key(8'h1C, ew, ea, ed);
    n_cmp++;
    if (xfers !== 10 || writes !== 10 || consec !== 0) begin
      n_err++;
      $display("FAIL b2b xfers=%0d writes=%0d consec=%0d required 10/10/0", xfers, writes, consec);
    end
    n_cmp++;
    if (cur_row !== 5'(m_row) || cur_col !== 7'(m_col)) begin
      n_err++;
      $display("FAIL b2b_cursor cur=(%0d,%0d) required (%0d,%0d)", cur_row, cur_col, m_row, m_col);
    end
  endtask

  task automatic test_random();
    int nw, wi, ew, r; logic [11:0] wa, ea; logic [7:0] wd, ed, la, code; bit tmo;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: code = 8'hF0;
        1: code = 8'hE0;
        2: code = 8'h1C;
        3: code = 8'h5A;
        4, 5: code = 8'h66;
        default: code = 8'($urandom_range(0, 255));
      endcase
      model_key(code, ew, ea, ed);
      send_key(code, nw, wi, wa, wd, la, tmo);
      n_cmp++;
      if (tmo || nw !== ew || (ew == 1 && (wi !== 2 || wa !== ea || wd !== ed)) ||
          cur_row !== 5'(m_row) || cur_col !== 7'(m_col)) begin
        n_err++;
        $display("FAIL rand[%0d] code=%h nw=%0d addr=%h data=%h cur=(%0d,%0d) required nw=%0d addr=%h data=%h cur=(%0d,%0d)",
                 i, code, nw, wa, wd, cur_row, cur_col, ew, ea, ed, m_row, m_col);
      end
    end
  endtask

  task automatic test_reset_midop();
    int t = 0, nw, wi, ew; logic [11:0] wa, ea; logic [7:0] wd, ed, la; bit tmo;
    sc_data = 8'h1C; sc_valid = 1'b1;
    @(posedge clk); #1; sc_valid = 1'b0; clrn = 1'b0;
    @(posedge clk); @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (buf_we !== 1'b0 || sc_ready !== 1'b0 || cur_row !== 5'd0 || cur_col !== 7'd0) begin
      n_err++;
      $display("FAIL rst_lookup we=%b rdy=%b cur=(%0d,%0d) required 0 0 (0,0)", buf_we, sc_ready, cur_row, cur_col);
    end
    clrn = 1'b1;
    model_reset();
    @(negedge clk);
    n_cmp++;
    if (buf_we !== 1'b1 || buf_addr !== 12'h000) begin
      n_err++; $display("FAIL rst_lookup_restart we=%b addr=%h required 1 000", buf_we, buf_addr);
    end
    while (buf_addr !== 12'h800 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    clrn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (buf_we !== 1'b0 || buf_addr !== 12'h000 || t >= 5000) begin
      n_err++; $display("FAIL rst_clear we=%b addr=%h required 0 000", buf_we, buf_addr);
    end
    clrn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (buf_we !== 1'b1 || buf_addr !== 12'h000) begin
      n_err++; $display("FAIL rst_clear_restart we=%b addr=%h required 1 000", buf_we, buf_addr);
    end
    wait_clear_done();
    model_key(8'h1C, ew, ea, ed);
    send_key(8'h1C, nw, wi, wa, wd, la, tmo);
    n_cmp++;
    if (tmo || nw !== 1 || wa !== 12'h000 || wd !== 8'h61 || cur_col !== 7'd1) begin
      n_err++;
      $display("FAIL rst_first_key nw=%0d addr=%h data=%h col=%0d required 1 000 61 1", nw, wa, wd, cur_col);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) lut_mem[i] = 8'($urandom_range(0, 255));
    lut_mem[8'h1C] = 8'h61;
    lut_mem[8'h5A] = 8'h0D;
    lut_mem[8'h66] = 8'h08;
    model_reset();
    test_reset();
    test_key_press();
    test_prefix();
    test_line_wrap();
    test_backspace();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
